// File: rtl/hyperbus_ctrl_if.sv
// hyperbus_ctrl_if: request/response and PHY signal bundle for hyperbus_ctrl.
// Host side : hbus_adr_i, hbus_dat_i, hbus_rrq, hbus_wrq in; hbus_dat_o, hbus_ready,
//             hbus_valid, hbus_busy, hbus_err out (all relative to the controller).
// PHY side  : phy_cs_n, phy_ck_en, phy_dq_o, phy_dq_oe, phy_rwds_o, phy_rwds_oe out;
//             phy_rwds_i, phy_dq_i, phy_rd_valid in.
// master = the controller, slave = the environment (FIFO + PHY).
interface hyperbus_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] hbus_adr_i;
    logic [15:0]           hbus_dat_i;
    logic [15:0]           hbus_dat_o;
    logic                  hbus_rrq;
    logic                  hbus_wrq;
    logic                  hbus_ready;
    logic                  hbus_valid;
    logic                  hbus_busy;
    logic                  hbus_err;
    logic                  phy_cs_n;
    logic                  phy_ck_en;
    logic [15:0]           phy_dq_o;
    logic                  phy_dq_oe;
    logic [1:0]            phy_rwds_o;
    logic                  phy_rwds_oe;
    logic [1:0]            phy_rwds_i;
    logic [15:0]           phy_dq_i;
    logic                  phy_rd_valid;

    modport master (
        input  hbus_adr_i, hbus_dat_i, hbus_rrq, hbus_wrq,
        input  phy_rwds_i, phy_dq_i, phy_rd_valid,
        output hbus_dat_o, hbus_ready, hbus_valid, hbus_busy, hbus_err,
        output phy_cs_n, phy_ck_en, phy_dq_o, phy_dq_oe, phy_rwds_o, phy_rwds_oe
    );

    modport slave (
        output hbus_adr_i, hbus_dat_i, hbus_rrq, hbus_wrq,
        output phy_rwds_i, phy_dq_i, phy_rd_valid,
        input  hbus_dat_o, hbus_ready, hbus_valid, hbus_busy, hbus_err,
        input  phy_cs_n, phy_ck_en, phy_dq_o, phy_dq_oe, phy_rwds_o, phy_rwds_oe
    );
endinterface

// File: rtl/hyperbus_ctrl.sv
// hyperbus_ctrl: single-word HyperBus read/write engine (CA, latency, data, CS hold).
// Ports: hbus_clk, hbus_rst (sync, active-high); bus (hyperbus_ctrl_if.master) carrying
// the host request/response signals and the SDR-abstracted PHY signals.
module hyperbus_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int LATENCY    = 6,
    parameter int CS_HOLD    = 2,
    parameter int RD_TIMEOUT = 32
) (
    input  logic            hbus_clk,
    input  logic            hbus_rst,
    hyperbus_ctrl_if.master bus
);
    localparam int CMAX_A = (2 * LATENCY > RD_TIMEOUT) ? 2 * LATENCY : RD_TIMEOUT;
    localparam int CMAX   = (CMAX_A > CS_HOLD) ? CMAX_A : CS_HOLD;
    localparam int CW     = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CA0, S_CA1, S_CA2, S_LAT, S_WDATA, S_RDATA, S_END
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [15:0]           wdat_q;
    logic [15:0]           rdat_q;
    logic                  rd_q;
    logic                  dbl_q;
    logic                  ready_q;
    logic                  valid_q;
    logic                  err_q;
    logic [31:0]           adr32;
    logic [47:0]           ca;
    logic [CW-1:0]         lat_last;
    logic                  accept;
    logic                  timeout;
    logic                  act;
    logic                  unused_rwds;

    assign unused_rwds = bus.phy_rwds_i[1];
    assign adr32       = 32'(adr_q);
    assign ca          = {rd_q, 1'b0, 1'b1, adr32[31:3], 13'd0, adr32[2:0]};
    assign lat_last    = dbl_q ? CW'(2 * LATENCY - 1) : CW'(LATENCY - 1);
    assign accept      = bus.hbus_rrq | bus.hbus_wrq;
    assign timeout     = cnt_q == CW'(RD_TIMEOUT - 1);
    // The shared counter restarts at zero on every state change.
    assign cnt_d       = (state_d != state_q) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge hbus_clk) begin
        if (hbus_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            rd_q    <= 1'b0;
            dbl_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && accept) begin
                adr_q  <= bus.hbus_adr_i;
                wdat_q <= bus.hbus_dat_i;
                rd_q   <= ~bus.hbus_wrq;
            end
            if (state_q == S_CA0) dbl_q <= bus.phy_rwds_i[0];
            if (state_q == S_RDATA && bus.phy_rd_valid) rdat_q <= bus.phy_dq_i;
            ready_q <= state_q == S_WDATA;
            valid_q <= state_q == S_RDATA && bus.phy_rd_valid;
            // A valid word arriving on the last timeout cycle suppresses the error.
            err_q   <= state_q == S_RDATA && !bus.phy_rd_valid && timeout;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? S_CA0 : S_IDLE;
            S_CA0:   state_d = S_CA1;
            S_CA1:   state_d = S_CA2;
            S_CA2:   state_d = S_LAT;
            S_LAT:   state_d = (cnt_q == lat_last) ? (rd_q ? S_RDATA : S_WDATA) : S_LAT;
            S_WDATA: state_d = S_END;
            S_RDATA: state_d = (bus.phy_rd_valid || timeout) ? S_END : S_RDATA;
            S_END:   state_d = (cnt_q == CW'(CS_HOLD - 1)) ? S_IDLE : S_END;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        act             = state_q != S_IDLE && state_q != S_END;
        bus.phy_cs_n    = ~act;
        bus.phy_ck_en   = act;
        bus.phy_dq_oe   = state_q == S_CA0 || state_q == S_CA1 || state_q == S_CA2 ||
                          state_q == S_WDATA;
        bus.phy_dq_o    = state_q == S_CA0   ? ca[47:32] :
                          state_q == S_CA1   ? ca[31:16] :
                          state_q == S_CA2   ? ca[15:0]  :
                          state_q == S_WDATA ? wdat_q    : 16'h0000;
        bus.phy_rwds_oe = state_q == S_WDATA;
        bus.phy_rwds_o  = 2'b00;
        bus.hbus_busy   = state_q != S_IDLE;
        bus.hbus_dat_o  = rdat_q;
        bus.hbus_ready  = ready_q;
        bus.hbus_valid  = valid_q;
        bus.hbus_err    = err_q;
    end
endmodule
